// File: rtl/mostrar_pkg.sv
// Shared definitions for the result display block.
//   state_e           : conversion FSM states
//   RefreshDivDefault : clocks per digit slot (1 kHz per digit at 100 MHz)
//   SegTable          : active-low {g,f,e,d,c,b,a} pattern per 4-bit code
package mostrar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StUpdate
  } state_e;

  localparam int unsigned RefreshDivDefault = 100000;

  // Entry N is the pattern for code N; codes 10-15 are dark.
  localparam logic [15:0][6:0] SegTable = {
    7'b1111111,  // 15
    7'b1111111,  // 14
    7'b1111111,  // 13
    7'b1111111,  // 12
    7'b1111111,  // 11
    7'b1111111,  // 10
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/dec_7seg.sv
// BCD to seven-segment decoder (purely combinational).
//   bcd_i : 4-bit digit code
//   seg_o : active-low cathodes {g,f,e,d,c,b,a}; codes above 9 are dark
module dec_7seg
  import mostrar_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SegTable[bcd_i];

endmodule

// File: rtl/mostrar_resultado.sv
// Converts a 16-bit product to five BCD digits (double dabble, one bit per
// clock) and multiplexes them onto an 8-anode seven-segment display.
//   CLK100MHZ : system clock
//   reset     : asynchronous active-high reset
//   producto  : product to show, sampled when listo is high in idle
//   listo     : one-cycle strobe, producto valid
//   ocupado   : high while a conversion is in progress
//   AN        : active-low anodes, AN[4:0] = digits 0..4, AN[7:5] unused
//   SEG       : active-low cathodes {g,f,e,d,c,b,a}
//   DP        : decimal point, always off
module mostrar_resultado
  import mostrar_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = RefreshDivDefault
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [15:0] producto,
  input  logic        listo,
  output logic        ocupado,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e      state_q;
  logic [15:0] shift_q;
  logic [19:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [19:0] disp_q;
  logic        ocupado_q;

  logic [RefW-1:0] refresh_q;
  logic [2:0]      digit_q;

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
  logic [19:0] bcd_adj;
  logic [35:0] dabble_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) begin
        bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
      end
    end
    dabble_d = {bcd_adj, shift_q} << 1;
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ocupado_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (listo) begin
            shift_q   <= producto;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            state_q   <= StConv;
          end
        end
        StConv: begin
          bcd_q   <= dabble_d[35:16];
          shift_q <= dabble_d[15:0];
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          disp_q    <= bcd_q;
          ocupado_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Digit multiplexing runs independently of the conversion.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      digit_q   <= (digit_q == 3'd4) ? 3'd0 : digit_q + 3'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Shifting the display register down by the digit index puts the current
  // digit in the low nibble; an all-zero remainder means this digit and all
  // higher ones are leading zeros.
  logic [19:0] disp_sh;
  logic        blank;

  always_comb begin
    disp_sh = disp_q >> {digit_q, 2'b00};
    blank   = (digit_q != 3'd0) && (disp_sh == 20'd0);
  end

  dec_7seg u_dec_7seg (
    .bcd_i (disp_sh[3:0]),
    .seg_o (SEG)
  );

  assign AN      = blank ? 8'hFF : {3'b111, ~(5'b00001 << digit_q)};
  assign DP      = 1'b1;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_mostrar_resultado.sv
module tb_mostrar_resultado;

  localparam int unsigned Div = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        listo = 1'b0;
  logic [15:0] producto = '0;
  logic        ocupado;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];

  int unsigned m_ref;
  int unsigned m_dig;

  typedef struct {
    logic [15:0] prod;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  mostrar_resultado #(.REFRESH_DIV(Div)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .producto  (producto),
    .listo     (listo),
    .ocupado   (ocupado),
    .AN        (an),
    .SEG       (seg),
    .DP        (dp)
  );

  // Reference digit-slot tracker.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ref <= 0;
      m_dig <= 0;
    end else if (m_ref == Div - 1) begin
      m_ref <= 0;
      m_dig <= (m_dig == 4) ? 0 : m_dig + 1;
    end else begin
      m_ref <= m_ref + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hFE);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; leaves listo low at the next falling edge.
  task automatic send(input logic [15:0] p, input logic [19:0] exp_bcd);
    producto = p;
    listo    = 1'b1;
    sb_q.push_back(exp_bcd);
    @(negedge clk);
    listo    = 1'b0;
  endtask

  task automatic check_display(input logic [19:0] bcd);
    int unsigned d;
    logic [19:0] sh;
    logic        blank;
    logic [7:0]  exp_an;
    for (int c = 0; c < 5 * Div; c++) begin
      d      = m_dig;
      sh     = bcd >> (4 * d);
      blank  = (d != 0) && (sh == 20'd0);
      exp_an = blank ? 8'hFF : {3'b111, ~(5'b00001 << d)};
      chk("an", 32'(an), 32'(exp_an));
      if (!blank) chk("seg", 32'(seg), 32'(seg_of(sh[3:0])));
      chk("dp", 32'(dp), 32'd1);
      chk("idle_ocupado", 32'(ocupado), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic wait_result(input int exp_busy);
    int n;
    logic [19:0] bcd;
    n = 0;
    while (ocupado === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      bcd = sb_q.pop_front();
      check_display(bcd);
    end
  endtask

  initial begin
    logic [15:0] r;

    vecs[0] = '{prod: 16'd65025, bcd: 20'h65025};
    vecs[1] = '{prod: 16'd7,     bcd: 20'h00007};
    vecs[2] = '{prod: 16'd100,   bcd: 20'h00100};
    vecs[3] = '{prod: 16'd0,     bcd: 20'h00000};
    vecs[4] = '{prod: 16'd65535, bcd: 20'h65535};
    vecs[5] = '{prod: 16'd10009, bcd: 20'h10009};
    vecs[6] = '{prod: 16'd9999,  bcd: 20'h09999};

    do_reset();

    foreach (vecs[i]) begin
      send(vecs[i].prod, vecs[i].bcd);
      wait_result(17);
    end

    for (int i = 0; i < 4; i++) begin
      r = 16'($urandom_range(0, 65535));
      send(r, to_bcd(32'(r)));
      wait_result(17);
    end

    // Second strobe during conversion must be dropped.
    send(16'd36, 20'h00036);
    repeat (4) @(negedge clk);
    producto = 16'd25;
    listo    = 1'b1;
    @(negedge clk);
    listo    = 1'b0;
    wait_result(12);

    // Reset partway through a conversion aborts it and clears the display.
    send(16'd255, 20'h00255);
    repeat (7) @(negedge clk);
    do_reset();
    sb_q.delete();
    check_display(20'h00000);
    send(16'd255, 20'h00255);
    wait_result(17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
